// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared state encoding and reply-byte defaults for the program loader
// Contents:
//   state_t             loader FSM states
//   ACK_BYTE_DEFAULT    reply byte for a successful load
//   NAK_BYTE_DEFAULT    reply byte for a length or checksum error
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_BODY   = 3'd1,
        S_CHECK  = 3'd2,
        S_SEND   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - loads a length-prefixed, checksummed program from UART words into instruction memory
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   recv_data, recv_valid   assembled 32-bit words from the UART receiver
//   start                   pulse, re-arms the loader from S_DONE / S_ERR
//   imem_we/addr/wdata      instruction memory write port (one write per body word)
//   tx_data, tx_start       reply byte (ACK/NAK) to the UART transmitter
//   tx_busy                 transmitter busy, holds off tx_start
//   load_done, load_error   levels, high in S_DONE / S_ERR respectively
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEFAULT,
    parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           recv_data,
    input  logic                  recv_valid,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  load_done,
    output logic                  load_error
);

    // 33 bits so that a full 2**32-ish header compares correctly for any width
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                state, state_n;
    logic [31:0]           count, count_n;
    logic [ADDR_WIDTH-1:0] index, index_n;
    logic [31:0]           sum, sum_n;
    logic                  ok, ok_n;

    logic                  imem_we_n;
    logic [ADDR_WIDTH-1:0] imem_addr_n;
    logic [31:0]           imem_wdata_n;
    logic [7:0]            tx_data_n;
    logic                  tx_start_n;

    always_comb begin
        state_n      = state;
        count_n      = count;
        index_n      = index;
        sum_n        = sum;
        ok_n         = ok;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        tx_data_n    = tx_data;
        tx_start_n   = 1'b0;

        case (state)
            S_HEADER: begin
                if (recv_valid) begin
                    count_n = recv_data;
                    index_n = '0;
                    sum_n   = '0;
                    if ({1'b0, recv_data} > MAX_WORDS) begin
                        tx_data_n = NAK_BYTE;
                        ok_n      = 1'b0;
                        state_n   = S_SEND;
                    end else if (recv_data == 32'd0) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (recv_valid) begin
                    imem_we_n    = 1'b1;
                    imem_addr_n  = index;
                    imem_wdata_n = recv_data;
                    // index may wrap after the final word of a full-size
                    // program; it is no longer used once we leave S_BODY
                    index_n      = index + 1'b1;
                    sum_n        = sum + recv_data;
                    if (32'(index) == count - 32'd1) begin
                        state_n = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (recv_valid) begin
                    ok_n      = (recv_data == sum);
                    tx_data_n = (recv_data == sum) ? ACK_BYTE : NAK_BYTE;
                    state_n   = S_SEND;
                end
            end
            S_SEND: begin
                // words arriving here are dropped; host waits for the reply
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    state_n    = ok ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_HEADER;
                end
            end
            default: begin
                state_n = S_HEADER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_HEADER;
            count      <= '0;
            index      <= '0;
            sum        <= '0;
            ok         <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            index      <= index_n;
            sum        <= sum_n;
            ok         <= ok_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            tx_data    <= tx_data_n;
            tx_start   <= tx_start_n;
            // registered from the next state so the levels track the state exactly
            load_done  <= (state_n == S_DONE);
            load_error <= (state_n == S_ERR);
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    localparam int AW = 4;

    logic          clk;
    logic          rstn;
    logic [31:0]   recv_data;
    logic          recv_valid;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          load_done;
    logic          load_error;

    uart_prog_loader #(.ADDR_WIDTH(AW), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int          wr_cnt = 0;
    int          tx_cnt = 0;
    int          b2b_cnt = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  last_tx = 8'h00;
    logic [31:0] last_addr = 32'h0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= 32'(imem_addr);
        end
        if (imem_we && prev_we) b2b_cnt <= b2b_cnt + 1;
        prev_we <= imem_we;
        if (tx_start) begin
            tx_cnt  <= tx_cnt + 1;
            last_tx <= tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        @(negedge clk);
        recv_data  = d;
        recv_valid = 1'b1;
        @(posedge clk);
        #1;
        recv_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // body word: the write must appear exactly one cycle after recv_valid
    task automatic send_body(input string tag, input logic [31:0] d, input logic [31:0] addr);
        @(negedge clk);
        recv_data  = d;
        recv_valid = 1'b1;
        @(posedge clk);
        #1;
        recv_valid = 1'b0;
        check({tag, "_we"}, 32'(imem_we), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), addr);
        check({tag, "_wdata"}, imem_wdata, d);
        repeat (3) @(posedge clk);
    endtask

    task automatic expect_reply(input string tag, input int tx0, input logic [7:0] byte_exp,
                                input logic done_exp, input logic err_exp);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_txcnt"}, 32'(tx_cnt - tx0), 32'd1);
        check({tag, "_txbyte"}, 32'(last_tx), 32'(byte_exp));
        check({tag, "_done"}, 32'(load_done), 32'(done_exp));
        check({tag, "_err"}, 32'(load_error), 32'(err_exp));
    endtask

    task automatic rearm(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_done_clr"}, 32'(load_done), 32'd0);
        check({tag, "_err_clr"}, 32'(load_error), 32'd0);
    endtask

    int w0;
    int t0;
    logic [31:0] s;

    initial begin
        rstn       = 1'b0;
        recv_data  = 32'h0;
        recv_valid = 1'b0;
        start      = 1'b0;
        tx_busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_txstart", 32'(tx_start), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // good 3-word load
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd3);
        send_body("t1w0", 32'h11111111, 32'd0);
        send_body("t1w1", 32'h22222222, 32'd1);
        send_body("t1w2", 32'h33333333, 32'd2);
        send_word(32'h66666666);
        check("t1_wrcnt", 32'(wr_cnt - w0), 32'd3);
        expect_reply("t1", t0, 8'hAA, 1'b1, 1'b0);
        rearm("t1");

        // same program, bad checksum
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd3);
        send_body("t2w0", 32'h11111111, 32'd0);
        send_body("t2w1", 32'h22222222, 32'd1);
        send_body("t2w2", 32'h33333333, 32'd2);
        send_word(32'h66666667);
        check("t2_wrcnt", 32'(wr_cnt - w0), 32'd3);
        expect_reply("t2", t0, 8'h55, 1'b0, 1'b1);
        rearm("t2");

        // empty program
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd0);
        send_word(32'd0);
        check("t3_wrcnt", 32'(wr_cnt - w0), 32'd0);
        expect_reply("t3", t0, 8'hAA, 1'b1, 1'b0);
        rearm("t3");

        // oversize header, later words ignored
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd17);
        expect_reply("t4", t0, 8'h55, 1'b0, 1'b1);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        check("t4_wrcnt", 32'(wr_cnt - w0), 32'd0);
        check("t4_txcnt_after", 32'(tx_cnt - t0), 32'd1);
        check("t4_err_hold", 32'(load_error), 32'd1);
        rearm("t4");

        // checksum wraps modulo 2**32
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd2);
        send_body("t5w0", 32'hFFFFFFFF, 32'd0);
        send_body("t5w1", 32'h00000002, 32'd1);
        send_word(32'h00000001);
        expect_reply("t5", t0, 8'hAA, 1'b1, 1'b0);
        rearm("t5");

        // maximum length 2**AW = 16, words 1..16, sum 136
        w0 = wr_cnt; t0 = tx_cnt;
        send_word(32'd16);
        s = 32'h0;
        for (int i = 0; i < 16; i++) begin
            send_word(32'(i + 1));
            s = s + 32'(i + 1);
        end
        check("t6_wrcnt", 32'(wr_cnt - w0), 32'd16);
        check("t6_lastaddr", last_addr, 32'd15);
        send_word(s);
        expect_reply("t6", t0, 8'hAA, 1'b1, 1'b0);
        rearm("t6");

        // transmitter busy for 50 cycles at S_SEND
        t0 = tx_cnt;
        tx_busy = 1'b1;
        send_word(32'd1);
        send_body("t7w0", 32'h00000005, 32'd0);
        send_word(32'h00000005);
        repeat (47) @(posedge clk);
        #1;
        check("t7_held_txstart", 32'(tx_start), 32'd0);
        check("t7_held_txcnt", 32'(tx_cnt - t0), 32'd0);
        @(negedge clk);
        tx_busy = 1'b0;
        @(posedge clk);
        #1;
        check("t7_pulse", 32'(tx_start), 32'd1);
        check("t7_pulse_byte", 32'(tx_data), 32'hAA);
        @(posedge clk);
        #1;
        check("t7_pulse_end", 32'(tx_start), 32'd0);
        check("t7_done", 32'(load_done), 32'd1);
        repeat (3) @(posedge clk);
        check("t7_txcnt", 32'(tx_cnt - t0), 32'd1);
        rearm("t7");

        // reset mid-body, then a fresh 1-word load
        t0 = tx_cnt;
        send_word(32'd3);
        send_body("t8w0", 32'hDEADBEEF, 32'd0);
        send_body("t8w1", 32'hCAFEF00D, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("t8_rst_addr", 32'(imem_addr), 32'd0);
        check("t8_rst_wdata", imem_wdata, 32'd0);
        check("t8_rst_txdata", 32'(tx_data), 32'd0);
        check("t8_rst_done", 32'(load_done), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        check("t8_no_tx", 32'(tx_cnt - t0), 32'd0);
        t0 = tx_cnt;
        send_word(32'd1);
        send_body("t9w0", 32'hABCD1234, 32'd0);
        send_word(32'hABCD1234);
        expect_reply("t9", t0, 8'hAA, 1'b1, 1'b0);

        check("no_back_to_back_we", 32'(b2b_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
